miner_work_scheduler: RTL and testbench

- Sequences the pipelined SHA-256 double-hash datapath.
- Accepts work (midstate + 96-bit header tail) from the comm block over a valid/ready handshake, then issues one nonce per hash_clk cycle into the hasher.
- Attributes each golden-ticket flag, which arrives PIPE_LATENCY cycles later, to the exact nonce that produced it, and suppresses stale results after a work switch.
- Queues golden nonces in a small FIFO for the comm block, and reports nonce-space exhaustion.

---
 rtl/miner_work_scheduler_if.sv | 29 ++
 rtl/miner_work_scheduler.sv | 106 ++++++++++
 tb/tb_miner_work_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_work_scheduler_if.sv
// rtl/miner_work_scheduler_if.sv - work, issue and golden-nonce signals of the hash scheduler
interface miner_work_scheduler_if;
    logic         rx_work_valid;
    logic         rx_work_ready;
    logic [255:0] rx_midstate;
    logic [95:0]  rx_data;
    logic [255:0] tx_state;
    logic [127:0] tx_data;
    logic         tx_issue_valid;
    logic         rx_is_golden_ticket;
    logic         tx_golden_valid;
    logic [31:0]  tx_golden_nonce;
    logic         rx_golden_ready;
    logic         tx_exhausted;
    logic         tx_overflow;
    logic         tx_busy;

    modport master (
        output rx_work_valid, rx_midstate, rx_data, rx_is_golden_ticket, rx_golden_ready,
        input  rx_work_ready, tx_state, tx_data, tx_issue_valid, tx_golden_valid,
        input  tx_golden_nonce, tx_exhausted, tx_overflow, tx_busy
    );

    modport slave (
        input  rx_work_valid, rx_midstate, rx_data, rx_is_golden_ticket, rx_golden_ready,
        output rx_work_ready, tx_state, tx_data, tx_issue_valid, tx_golden_valid,
        output tx_golden_nonce, tx_exhausted, tx_overflow, tx_busy
    );
endinterface

// File: rtl/miner_work_scheduler.sv
// rtl/miner_work_scheduler.sv - nonce issue sequencer with result attribution and golden-nonce FIFO
module miner_work_scheduler #(
    parameter int unsigned PIPE_LATENCY = 130,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] NONCE_START  = 32'h0
) (
    input logic                    hash_clk,
    input logic                    reset,
    miner_work_scheduler_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_next;
    logic                    accept, last_issue, drain_done;
    logic [7:0]              drain_cnt;
    logic [PIPE_LATENCY-1:0] dl_valid;
    logic [31:0]             dl_nonce [PIPE_LATENCY];
    logic [31:0]             fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [AW:0]             count;
    logic                    push, pop, write, empty, full;

    assign bus.rx_work_ready = !reset;
    assign accept      = bus.rx_work_valid && bus.rx_work_ready;
    assign last_issue  = (state == RUN) && (bus.tx_data[127:96] == 32'hFFFF_FFFF);
    assign drain_done  = (state == DRAIN) && (drain_cnt == 8'(PIPE_LATENCY - 1));
    assign bus.tx_busy = (state != IDLE);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     if (last_issue) state_next = DRAIN;
                DRAIN:   if (drain_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Issue registers double as the latched work: tx_state is the midstate, tx_data[95:0] the tail.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state              <= IDLE;
            drain_cnt          <= '0;
            bus.tx_issue_valid <= 1'b0;
            bus.tx_state       <= '0;
            bus.tx_data        <= '0;
            bus.tx_exhausted   <= 1'b0;
            dl_valid           <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
            if (accept) begin
                bus.tx_state       <= bus.rx_midstate;
                bus.tx_data        <= {NONCE_START, bus.rx_data};
                bus.tx_issue_valid <= 1'b1;
                bus.tx_exhausted   <= 1'b0;
            end else if (state_next == RUN) begin
                bus.tx_data[127:96] <= bus.tx_data[127:96] + 32'd1;
                bus.tx_issue_valid  <= 1'b1;
            end else begin
                bus.tx_issue_valid <= 1'b0;
                if (drain_done) bus.tx_exhausted <= 1'b1;
            end
            // A work switch invalidates every tag still in flight, including this cycle's issue.
            dl_valid <= accept ? '0 : {dl_valid[PIPE_LATENCY-2:0], bus.tx_issue_valid};
        end
    end

    always_ff @(posedge hash_clk) begin
        dl_nonce[0] <= bus.tx_data[127:96];
        for (int i = 1; i < PIPE_LATENCY; i++) dl_nonce[i] <= dl_nonce[i-1];
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign push  = dl_valid[PIPE_LATENCY-1] && bus.rx_is_golden_ticket;
    assign pop   = bus.rx_golden_ready && !empty;
    assign write = push && (!full || pop);

    assign bus.tx_golden_valid = !empty;
    assign bus.tx_golden_nonce = fifo_mem[rd_ptr];

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            bus.tx_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (write) begin
                fifo_mem[wr_ptr] <= dl_nonce[PIPE_LATENCY-1];
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, write} - {{AW{1'b0}}, pop};
            if (push && !write) bus.tx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_miner_work_scheduler.sv
// tb/tb_miner_work_scheduler.sv - randomized and directed bench with a cycle-indexed reference model
module tb_miner_work_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic         wv  [2];
    logic [255:0] mid [2];
    logic [95:0]  dat [2];
    logic         gt  [2];
    logic         gr  [2];
    int           n_vec = 0;
    int           n_err = 0;
    longint       tcyc  = 0;

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL u%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tcyc++;
    endtask

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int          L  = (g == 0) ? 130 : 2;
        localparam logic [31:0] NS = (g == 0) ? 32'h0 : 32'hFFFF_FFFD;

        miner_work_scheduler_if bus ();

        miner_work_scheduler #(.PIPE_LATENCY(L), .FIFO_DEPTH(4), .NONCE_START(NS)) dut (
            .hash_clk (clk),
            .reset    (rst),
            .bus      (bus.slave)
        );

        assign bus.rx_work_valid       = wv[g];
        assign bus.rx_midstate         = mid[g];
        assign bus.rx_data             = dat[g];
        assign bus.rx_is_golden_ticket = gt[g];
        assign bus.rx_golden_ready     = gr[g];

        // Model: issues[c] is the nonce on the hasher during cycle c; a flag at cycle c refers to issues[c-L].
        bit           started = 0;
        bit           active  = 0;
        longint       cyc     = 0;
        longint       last_c  = 0;
        longint       nxt     = 0;
        int unsigned  issues [longint];
        int unsigned  q [$];
        logic [255:0] m_state;
        logic [127:0] m_data;
        logic         m_issue, m_busy, m_exh, m_ovf;

        always @(posedge clk) begin
            if (rst) begin
                started = 1; active = 0; nxt = 0;
                issues.delete(); q.delete();
                m_state = '0; m_data = '0;
                m_issue = 0; m_busy = 0; m_exh = 0; m_ovf = 0;
            end else if (started) begin
                if (gr[g] && q.size() > 0) void'(q.pop_front());
                if (gt[g] && issues.exists(cyc - L)) begin
                    if (q.size() < 4) q.push_back(issues[cyc - L]);
                    else m_ovf = 1;
                end
                if (wv[g]) begin
                    for (longint k = cyc - L + 1; k <= cyc; k++)
                        if (issues.exists(k)) issues.delete(k);
                    active = 1; nxt = longint'(NS);
                    m_state = mid[g]; m_data[95:0] = dat[g];
                end
                if (active && nxt <= 64'hFFFF_FFFF) begin
                    m_issue = 1; m_busy = 0; m_exh = 0;
                    m_data[127:96] = nxt[31:0];
                    issues[cyc + 1] = nxt[31:0];
                    if (nxt == 64'hFFFF_FFFF) last_c = cyc + 1;
                    nxt++;
                    m_busy = 1;
                end else begin
                    m_issue = 0;
                    m_busy  = active && (cyc + 1 <= last_c + L);
                    m_exh   = active && (cyc + 1 >  last_c + L);
                end
                if (issues.exists(cyc - L)) issues.delete(cyc - L);
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (started) begin
                chk(g, "work_ready",   bus.rx_work_ready,   !rst);
                chk(g, "issue_valid",  bus.tx_issue_valid,  m_issue);
                chk(g, "tx_state",     bus.tx_state,        m_state);
                chk(g, "tx_data",      bus.tx_data,         m_data);
                chk(g, "busy",         bus.tx_busy,         m_busy);
                chk(g, "exhausted",    bus.tx_exhausted,    m_exh);
                chk(g, "overflow",     bus.tx_overflow,     m_ovf);
                chk(g, "golden_valid", bus.tx_golden_valid, q.size() != 0);
                if (q.size() != 0) chk(g, "golden_nonce", bus.tx_golden_nonce, q[0]);
            end
        end
    end

    localparam int L0 = 130;
    logic [255:0] m0, m1;
    logic [95:0]  d0, d1;
    longint       acc0, a, a2, s;

    initial begin
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            wv[i] = 0; gt[i] = 0; gr[i] = 0; mid[i] = '0; dat[i] = '0;
        end
        repeat (3) step();
        chk(0, "rst_ready",        g_inst[0].bus.rx_work_ready,   0);
        chk(0, "rst_issue_valid",  g_inst[0].bus.tx_issue_valid,  0);
        chk(0, "rst_busy",         g_inst[0].bus.tx_busy,         0);
        chk(0, "rst_golden_valid", g_inst[0].bus.tx_golden_valid, 0);
        chk(0, "rst_tx_data",      g_inst[0].bus.tx_data,         0);
        rst = 0;
        step();
        chk(0, "ready_after_rst",  g_inst[0].bus.rx_work_ready,   1);
        chk(0, "rst_golden_nonce", g_inst[0].bus.tx_golden_nonce, 0);

        // Basic issue on both instances, exhaustion on instance 1.
        m0 = r256(); m1 = r256(); d0 = r256()[95:0]; d1 = r256()[95:0];
        wv[0] = 1; mid[0] = m0; dat[0] = d0;
        wv[1] = 1; mid[1] = m1; dat[1] = d1;
        acc0 = tcyc;
        step();
        wv[0] = 0; wv[1] = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 3) begin
                chk(0, "basic_data",  g_inst[0].bus.tx_data,  {32'(k - 1), d0});
                chk(0, "basic_state", g_inst[0].bus.tx_state, m0);
                chk(1, "exh_data",    g_inst[1].bus.tx_data,  {32'hFFFF_FFFD + 32'(k - 1), d1});
            end
            if (k == 4) begin
                chk(1, "exh_no_issue", g_inst[1].bus.tx_issue_valid, 0);
                chk(1, "exh_drain_busy", g_inst[1].bus.tx_busy, 1);
            end
            if (k == 6) begin
                chk(1, "exh_flag", g_inst[1].bus.tx_exhausted, 1);
                chk(1, "exh_idle", g_inst[1].bus.tx_busy, 0);
            end
            step();
        end
        wv[1] = 1;
        step();
        wv[1] = 0;
        chk(1, "exh_cleared", g_inst[1].bus.tx_exhausted, 0);
        chk(1, "restart_nonce", g_inst[1].bus.tx_data[127:96], 32'hFFFF_FFFD);

        // Attribution: flag at cycle 1+L+5 belongs to nonce 5.
        while (tcyc < acc0 + 1 + L0 + 5) step();
        gt[0] = 1;
        step();
        gt[0] = 0;
        chk(0, "attr_valid", g_inst[0].bus.tx_golden_valid, 1);
        chk(0, "attr_nonce", g_inst[0].bus.tx_golden_nonce, 5);
        gr[0] = 1;
        step();
        gr[0] = 0;
        chk(0, "attr_popped", g_inst[0].bus.tx_golden_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            gt[0] = ($urandom % 4) == 0;
            gr[0] = $urandom % 2;
            wv[1] = ($urandom % 16) == 0;
            mid[1] = r256(); dat[1] = r256()[95:0];
            gt[1] = $urandom % 2;
            gr[1] = $urandom % 2;
            step();
        end
        wv[1] = 0; gt[1] = 0; gr[1] = 0;
        gt[0] = 0; gr[0] = 1;
        repeat (6) step();
        gr[0] = 0;

        // Work switch: only the flag aligned with the accept cycle survives.
        m0 = r256(); d0 = r256()[95:0];
        a = tcyc;
        wv[0] = 1; mid[0] = m0; dat[0] = d0; gt[0] = 1;
        step();
        wv[0] = 0;
        chk(0, "switch_nonce", g_inst[0].bus.tx_data, {32'h0, d0});
        while (tcyc < a + L0 + 1) step();
        gt[0] = 0;
        step();
        chk(0, "switch_valid", g_inst[0].bus.tx_golden_valid, 1);
        chk(0, "switch_nonce_old", g_inst[0].bus.tx_golden_nonce, 32'(a - L0 - acc0 - 1));
        gr[0] = 1;
        step();
        gr[0] = 0;
        chk(0, "switch_only_one", g_inst[0].bus.tx_golden_valid, 0);

        // Reset mid-run with a full FIFO and flags still arriving.
        gt[0] = 1;
        repeat (8) step();
        chk(0, "prerst_full", g_inst[0].bus.tx_golden_valid, 1);
        rst = 1;
        repeat (2) step();
        rst = 0;
        repeat (L0 + 10) step();
        gt[0] = 0;
        chk(0, "postrst_golden", g_inst[0].bus.tx_golden_valid, 0);
        chk(0, "postrst_overflow", g_inst[0].bus.tx_overflow, 0);
        chk(0, "postrst_busy", g_inst[0].bus.tx_busy, 0);

        // Overflow: six results into a four-deep FIFO.
        a2 = tcyc;
        wv[0] = 1;
        step();
        wv[0] = 0;
        while (tcyc < a2 + L0 + 4) step();
        s = tcyc;
        gt[0] = 1;
        repeat (6) step();
        gt[0] = 0;
        chk(0, "ovf_set", g_inst[0].bus.tx_overflow, 1);
        gr[0] = 1;
        for (int i = 0; i < 4; i++) begin
            chk(0, "ovf_valid", g_inst[0].bus.tx_golden_valid, 1);
            chk(0, "ovf_order", g_inst[0].bus.tx_golden_nonce, 32'(s - L0 - a2 - 1 + i));
            step();
        end
        gr[0] = 0;
        chk(0, "ovf_drained", g_inst[0].bus.tx_golden_valid, 0);
        chk(0, "ovf_sticky", g_inst[0].bus.tx_overflow, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
